ram_2p: RTL

- Parametrised true dual-port synchronous RAM for the FPGA memory set.
- Successor to the single-port byte-enabled RAM, adding:
  - configurable data width, depth and read latency;
  - two independent request ports (A, B) with request/grant/rvalid handshakes;
  - defined collision and out-of-range behaviour.
- Used as shared code/data memory between the core and a DMA/debug master.

---
 rtl/ram_2p.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/ram_2p.sv
// ram_2p: true dual-port synchronous RAM with req/gnt/rvalid handshakes.
// Shared code/data memory between the core and a DMA/debug master.
//
// Ports (x = a | b):
//   clk, rst          clock (rising edge), async active-high reset
//   x_req / x_gnt     request in; grant out (high whenever rst is low)
//   x_addr            byte address; low log2(DATA_WIDTH/8) bits ignored
//   x_we, x_be        write enable, per-byte enables
//   x_wdata           write data
//   x_rdata           read data, READ_LATENCY cycles after accept
//   x_rvalid, x_rerr  one-cycle response pulse; error on that response
//
// Optional build macro KMIE_RAM_BYTE_PARITY_EN adds an even-parity bit
// per stored byte; a mismatching byte raises x_rerr on read.
module ram_2p #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 4096,
    parameter int READ_LATENCY = 1,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    a_req,
    output logic                    a_gnt,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic                    a_we,
    input  logic [DATA_WIDTH/8-1:0] a_be,
    input  logic [DATA_WIDTH-1:0]   a_wdata,
    output logic [DATA_WIDTH-1:0]   a_rdata,
    output logic                    a_rvalid,
    output logic                    a_rerr,
    input  logic                    b_req,
    output logic                    b_gnt,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    input  logic                    b_we,
    input  logic [DATA_WIDTH/8-1:0] b_be,
    input  logic [DATA_WIDTH-1:0]   b_wdata,
    output logic [DATA_WIDTH-1:0]   b_rdata,
    output logic                    b_rvalid,
    output logic                    b_rerr
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int SH = (NB > 1) ? $clog2(NB) : 0;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(DEPTH);

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || DATA_WIDTH > 128
        || (READ_LATENCY != 1 && READ_LATENCY != 2)) begin : g_bad_cfg
        $fatal(1, "ram_2p: illegal DATA_WIDTH or READ_LATENCY");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
`ifdef KMIE_RAM_BYTE_PARITY_EN
    logic [NB-1:0]         par [DEPTH];
`endif

    // Both ports packed into two-entry bundles, index 0 = A, 1 = B.
    logic [1:0]                 req;
    logic [1:0]                 we;
    logic [1:0]                 acc;
    logic [1:0]                 in_rng;
    logic [1:0]                 rd_err;
    logic [1:0][ADDR_WIDTH-1:0] addr;
    logic [1:0][ADDR_WIDTH-1:0] idx_full;
    logic [1:0][IW-1:0]         idx;
    logic [1:0][NB-1:0]         be;
    logic [1:0][DATA_WIDTH-1:0] wdata;
    logic [1:0][DATA_WIDTH-1:0] rd_word;
    logic [1:0][DATA_WIDTH-1:0] rdata_o;
    logic [1:0]                 rvalid_o;
    logic [1:0]                 rerr_o;

    assign req   = {b_req, a_req};
    assign we    = {b_we, a_we};
    assign addr  = {b_addr, a_addr};
    assign be    = {b_be, a_be};
    assign wdata = {b_wdata, a_wdata};

    assign a_gnt = ~rst;
    assign b_gnt = ~rst;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            idx_full[p] = addr[p] >> SH;
            in_rng[p]   = idx_full[p] < LIMIT;
            idx[p]      = idx_full[p][IW-1:0];
            acc[p]      = req[p] & ~rst;
            // Out-of-range reads never touch the array: no aliasing.
            rd_word[p]  = in_rng[p] ? mem[idx[p]] : '0;
            rd_err[p]   = ~in_rng[p];
`ifdef KMIE_RAM_BYTE_PARITY_EN
            if (in_rng[p]) begin
                for (int i = 0; i < NB; i++) begin
                    if ((^mem[idx[p]][8*i +: 8]) != par[idx[p]][i]) begin
                        rd_err[p] = 1'b1;
                    end
                end
            end
`endif
        end
    end

    // Port B is applied first so port A's later assignment wins on
    // bytes enabled by both ports in the same cycle.
    always_ff @(posedge clk) begin
        for (int p = 1; p >= 0; p--) begin
            if (acc[p] && we[p] && in_rng[p]) begin
                for (int i = 0; i < NB; i++) begin
                    if (be[p][i]) begin
                        mem[idx[p]][8*i +: 8] <= wdata[p][8*i +: 8];
`ifdef KMIE_RAM_BYTE_PARITY_EN
                        par[idx[p]][i] <= ^wdata[p][8*i +: 8];
`endif
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic                  v1;
        logic                  e1;
        logic [DATA_WIDTH-1:0] d1;

        // Stage 1 samples the pre-write word (read-first); data only
        // moves on an accept so rdata holds between responses.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v1 <= 1'b0;
                e1 <= 1'b0;
                d1 <= '0;
            end else begin
                v1 <= acc[p];
                e1 <= acc[p] & rd_err[p];
                if (acc[p]) begin
                    d1 <= rd_word[p];
                end
            end
        end

        if (READ_LATENCY == 2) begin : g_lat2
            logic                  v2;
            logic                  e2;
            logic [DATA_WIDTH-1:0] d2;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v2 <= 1'b0;
                    e2 <= 1'b0;
                    d2 <= '0;
                end else begin
                    v2 <= v1;
                    e2 <= e1;
                    if (v1) begin
                        d2 <= d1;
                    end
                end
            end

            assign rvalid_o[p] = v2;
            assign rerr_o[p]   = e2;
            assign rdata_o[p]  = d2;
        end else begin : g_lat1
            assign rvalid_o[p] = v1;
            assign rerr_o[p]   = e1;
            assign rdata_o[p]  = d1;
        end
    end

    assign a_rdata  = rdata_o[0];
    assign a_rvalid = rvalid_o[0];
    assign a_rerr   = rerr_o[0];
    assign b_rdata  = rdata_o[1];
    assign b_rvalid = rvalid_o[1];
    assign b_rerr   = rerr_o[1];

endmodule
